icache_ctrl: RTL and testbench

- Direct-mapped instruction-cache controller that sits directly upstream of tag_ram and the line data RAM.
- Accepts fetch requests from the core and drives the tag RAM lookup and refill writes.
- Decides hit/miss and runs the line-refill handshake with the memory side.
- Keeps the per-entry valid bits itself; the tag RAM stores tags only.

---
 rtl/icache_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// ============================================================================
// Module   : icache_ctrl
// Brief    : Direct-mapped instruction-cache controller. Owns the per-entry
//            valid bits, drives tag/data RAM lookup and line refill, and runs
//            the memory-side refill handshake.
//            Optional hit/miss counters are enabled with ICACHE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           resp_valid,
    output logic [31:0]                    resp_data,
`ifdef ICACHE_PERF_EN
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt,
`endif
    input  logic                           flush,
    output logic [INDEX_W-1:0]             tag_index,
    output logic                           tag_wen,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] tag_wdata,
    input  logic [ADDR_W-INDEX_W-OFFSET_W-1:0] tag_rdata,
    output logic [INDEX_W+OFFSET_W-3:0]    data_index,
    output logic                           data_wen,
    output logic [31:0]                    data_wdata,
    input  logic [31:0]                    data_rdata,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [31:0]                    mem_rdata
);

    localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CNT_W       = OFFSET_W - 2;
    localparam int WORDS       = 2 ** CNT_W;
    localparam int NUM_ENTRIES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOOKUP   = 2'd1,
        S_MISS_REQ = 2'd2,
        S_REFILL   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:2]        addr_q, addr_d;
    logic [NUM_ENTRIES-1:0]   valid_q, valid_d;
    logic                     flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [TAG_W-1:0]         lat_tag;
    logic [INDEX_W-1:0]       lat_idx;
    logic [CNT_W-1:0]         lat_word;
    logic [INDEX_W-1:0]       req_idx;
    logic [CNT_W-1:0]         req_word;
    logic                     hit;
    logic                     last_beat;
    logic                     unused_addr_bits;

    assign lat_tag   = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign lat_idx   = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign lat_word  = addr_q[OFFSET_W-1:2];
    assign req_idx   = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign req_word  = req_addr[OFFSET_W-1:2];
    assign unused_addr_bits = ^req_addr[1:0];

    assign hit       = valid_q[lat_idx] && (tag_rdata == lat_tag);
    assign last_beat = (cnt_q == CNT_W'(WORDS - 1));

    assign resp_data = data_rdata;
    assign mem_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_req      = 1'b0;
        tag_wen      = 1'b0;
        data_wen     = 1'b0;
        tag_index    = lat_idx;
        tag_wdata    = lat_tag;
        data_index   = {lat_idx, lat_word};
        data_wdata   = mem_rdata;

        case (state_q)
            S_IDLE: begin
                tag_index  = req_idx;
                data_index = {req_idx, req_word};
                req_ready  = !flush && !flush_pend_q;
                // A live or deferred flush owns this cycle; requests wait.
                if (flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid) begin
                    addr_d  = req_addr[ADDR_W-1:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                data_index = {lat_idx, cnt_q};
                if (mem_rvalid) begin
                    data_wen = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        tag_wen          = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        state_d          = S_LOOKUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush && (state_q != S_IDLE)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic        relookup_q, relookup_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // The lookup that follows a refill always hits and is not a real hit.
    always_comb begin
        relookup_d = relookup_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_REFILL && mem_rvalid && last_beat) begin
            relookup_d = 1'b1;
        end
        if (state_q == S_LOOKUP) begin
            relookup_d = 1'b0;
            if (hit && !relookup_q) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            relookup_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            relookup_q <= relookup_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
// Module   : tb_icache_ctrl
// Brief    : Self-checking bench for icache_ctrl with tag/data RAM models and
//            a line-level cache reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush;
    logic [5:0]  tag_index;
    logic        tag_wen;
    logic [21:0] tag_wdata;
    logic [21:0] tag_rdata;
    logic [7:0]  data_index;
    logic        data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Tag and data RAMs: combinational read, write on clock edge.
    logic [21:0] tag_mem [64];
    logic [31:0] data_mem [256];
    assign tag_rdata  = tag_mem[tag_index];
    assign data_rdata = data_mem[data_index];
    always @(posedge clk) begin
        if (tag_wen)  tag_mem[tag_index]   <= tag_wdata;
        if (data_wen) data_mem[data_index] <= data_wdata;
    end

    // Reference model: which line each entry holds and its contents.
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_line  [64][4];
    int          exp_hits = 0;
    int          exp_misses = 0;

    icache_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
`ifdef ICACHE_PERF_EN
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
`endif
        .flush      (flush),
        .tag_index  (tag_index),
        .tag_wen    (tag_wen),
        .tag_wdata  (tag_wdata),
        .tag_rdata  (tag_rdata),
        .data_index (data_index),
        .data_wen   (data_wen),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch from IDLE; optionally pulse flush or reset on a refill beat.
    task automatic fetch(input logic [31:0] addr, input int flush_beat, input int rst_beat);
        logic [21:0] tg;
        logic [5:0]  ix;
        logic [1:0]  wd;
        logic [1:0]  bb;
        logic [31:0] line [4];
        bit          is_hit;
        tg = addr[31:10];
        ix = addr[9:4];
        wd = addr[3:2];
        is_hit = m_valid[ix] && (m_tag[ix] == tg);

        @(negedge clk);
        #1 chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        #1;
        if (is_hit) begin
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_data", resp_data, m_line[ix][wd]);
            chk("hit_no_mem_req", mem_req, 0);
            exp_hits++;
            return;
        end
        chk("miss_no_resp", resp_valid, 0);
        exp_misses++;

        @(negedge clk);
        #1 chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, {addr[31:4], 4'h0});
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1 chk("mem_req_held", mem_req, 1);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("mem_req_dropped", mem_req, 0);

        for (int b = 0; b < 4; b++) begin
            bb = b[1:0];
            repeat ($urandom_range(0, 1)) begin
                #1 chk("gap_no_wen", data_wen, 0);
                @(negedge clk);
            end
            line[b]    = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = line[b];
            if (b == flush_beat) flush = 1'b1;
            if (b == rst_beat) begin
                rstn = 1'b0;
                #1;
                chk("rst_mem_req", mem_req, 0);
                chk("rst_tag_wen", tag_wen, 0);
                chk("rst_data_wen", data_wen, 0);
                chk("rst_resp_valid", resp_valid, 0);
                @(negedge clk);
                rstn = 1'b1;
                for (int k = b + 1; k < 4; k++) begin
                    mem_rdata = $urandom;
                    #1;
                    chk("stale_beat_data_wen", data_wen, 0);
                    chk("stale_beat_tag_wen", tag_wen, 0);
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                model_clear();
                exp_hits   = 0;
                exp_misses = 0;
                return;
            end
            #1;
            chk("beat_data_wen", data_wen, 1);
            chk("beat_data_index", data_index, {ix, bb});
            chk("beat_data_wdata", data_wdata, line[b]);
            chk("beat_tag_wen", tag_wen, (b == 3));
            if (b == 3) begin
                chk("beat_tag_index", tag_index, ix);
                chk("beat_tag_wdata", tag_wdata, tg);
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            flush      = 1'b0;
        end
        #1;
        chk("refill_resp_valid", resp_valid, 1);
        chk("refill_resp_data", resp_data, line[wd]);
        m_valid[ix] = 1'b1;
        m_tag[ix]   = tg;
        for (int i = 0; i < 4; i++) m_line[ix][i] = line[i];
        if (flush_beat >= 0) begin
            @(negedge clk);
            #1 chk("pending_flush_not_ready", req_ready, 0);
            model_clear();
        end
    endtask

    task automatic flush_idle(input logic [31:0] addr);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = addr;
        #1 chk("flush_idle_not_ready", req_ready, 0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flush_idle_no_resp", resp_valid, 0);
        chk("flush_idle_ready_after", req_ready, 1);
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        int          fb;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 64; i++)  tag_mem[i]  = 22'($urandom);
        for (int i = 0; i < 256; i++) data_mem[i] = $urandom;
        model_clear();

        repeat (2) @(negedge clk);
        #1;
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_tag_wen", tag_wen, 0);
        chk("reset_data_wen", data_wen, 0);
        rstn = 1'b1;
        #1 chk("reset_req_ready", req_ready, 1);

        fetch(32'h0000_1040, -1, -1);
        fetch(32'h0000_104C, -1, -1);
`ifdef ICACHE_PERF_EN
        #1;
        chk("perf_hit_cnt_early", hit_cnt, 1);
        chk("perf_miss_cnt_early", miss_cnt, 1);
`endif
        fetch(32'h0000_1440, -1, -1);
        fetch(32'h0000_1040, -1, -1);
        flush_idle(32'h0000_1440);
        fetch(32'h0000_1440, -1, -1);
        fetch(32'h0000_1444, -1, -1);
        fetch(32'h0000_2040, -1, 2);
        fetch(32'h0000_2040, -1, -1);
        fetch(32'h0000_1040, -1, 1);
        fetch(32'h0000_1040, -1, -1);

        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            a[31:10] = 22'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: a[9:4] = 6'd0;
                1: a[9:4] = 6'd1;
                2: a[9:4] = 6'd2;
                default: a[9:4] = 6'd63;
            endcase
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 15) == 0) flush_idle(a);
            fetch(a, fb, -1);
        end

`ifdef ICACHE_PERF_EN
        #1;
        chk("perf_hit_cnt_final", hit_cnt, exp_hits);
        chk("perf_miss_cnt_final", miss_cnt, exp_misses);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
